ysyx_040066_dmem_bridge: RTL and testbench
==========================================

Name: ysyx_040066_dmem_bridge

Overview:
Data-side memory bridge directly downstream of the CPU core's M stage. It consumes the core's single-outstanding data request (MemRd/MemWr, addr, wr_len, wr_mask, data_Wr) and runs it as one AXI4-lite-style transaction on a 64-bit bus. It returns the raw 64-bit beat plus a one-cycle completion pulse (data_valid) and an error flag (data_error) to the core. Lane extraction and sign extension stay in the core's WB stage; the bridge never shifts data.

Parameters:
ADDR_W, 32, bus address width; request addr bits above ADDR_W must be zero.
DATA_W, 64, bus data width; fixed at 64, other values unsupported.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
MemRd  in  1  core read request, held until data_valid
MemWr  in  1  core write request, held until data_valid
addr  in  64  byte address
wr_len  in  3  access size log2 (0=1B, 1=2B, 2=4B, 3=8B); used for reads and writes
wr_mask  in  8  byte strobes, already lane-aligned
data_Wr  in  64  write data, already lane-aligned
data_Rd  out  64  read beat, unshifted
data_valid  out  1  one-cycle completion pulse
data_error  out  1  qualifies data_valid: access fault
araddr  out  ADDR_W  read address
arsize  out  3  read size
arvalid  out  1  read address valid
arready  in  1  read address ready
rdata  in  64  read data
rresp  in  2  read response
rvalid  in  1  read data valid
rready  out  1  read data ready
awaddr  out  ADDR_W  write address
awsize  out  3  write size
awvalid  out  1  write address valid
awready  in  1  write address ready
wdata  out  64  write data
wstrb  out  8  write strobes
wvalid  out  1  write data valid
wready  in  1  write data ready
bresp  in  2  write response
bvalid  in  1  write response valid
bready  out  1  write response ready

Behaviour:
- States: IDLE, AR, R, W, B, RESP. All outputs are registered.
- Reset (synchronous, active-high): state IDLE; every valid/ready output, data_valid and data_error cleared to 0; data_Rd 0. A reset mid-transaction abandons it; the slave is reset on the same rst.
- IDLE: samples MemRd/MemWr. It latches addr, size, mask and data into request registers, then:
  - Pre-check fault → RESP with error=1; no bus traffic.
  - Otherwise MemRd → AR, MemWr → W.
- Pre-check fault means any of:
  - addr not aligned to 2^wr_len;
  - addr[63:ADDR_W] != 0;
  - wr_len > 3;
  - MemRd && MemWr both high.
- AR: arvalid=1 with latched address/size. On arvalid&&arready → R.
- R: rready=1. On rvalid → capture rdata into data_Rd and set error = (rresp != 0), then → RESP.
- W: awvalid and wvalid both rise on entry.
  - Each drops independently after its own handshake.
  - Handshakes in the same cycle are legal.
  - When both are done → B.
- B: bready=1. On bvalid → error = (bresp != 0), then → RESP.
- RESP: data_valid=1 for exactly one cycle, with data_error=error; → IDLE.
- data_Rd holds its value until the next read capture. For writes, data_Rd is unchanged.
- Minimum latency from request seen in IDLE to data_valid, with zero-wait slave:
  - read: 3 cycles (IDLE→AR→R→RESP);
  - write: 3 cycles;
  - pre-check fault: 1 cycle.
- The cycle after RESP is IDLE. A back-to-back request held by the core is accepted there; there is no bubble beyond that.
- Requests are latched once. Changes on core inputs during AR/R/W/B are ignored.
- If the core drops the request mid-transaction, the bridge finishes the bus transaction and still pulses data_valid. The core ignores the pulse when not blocked.
- Exactly one transaction is outstanding at a time. Valid outputs never drop before their handshake.

Decomposition:
- Package ysyx_040066_dmem_pkg holds:
  - the state enum;
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D;
  - resp codes OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11;
  - the alignment-check function.
- No sub-module: the FSM plus request registers form a single module.

Test Plan:
- Aligned 8B read at 0x80000008, arready and rvalid immediate, rdata=0x1122334455667788, rresp=0 → data_valid at cycle 3, data_error=0, data_Rd=0x1122334455667788; arsize=3.
- 4B write at 0x80000004, wr_mask=0xF0, awready 2 cycles late, wready immediate, bresp=0 → wvalid drops after 1 cycle, awvalid after 3, one data_valid pulse, wstrb=0xF0.
- 2B read at 0x80000001 → data_valid+data_error the next cycle, arvalid never asserted.
- Read with rresp=SLVERR, and separately addr=0x1_0000_0000 → data_error=1 with one pulse each; the latter produces no bus traffic.
- Back-to-back: a read completes, and the core holds MemWr in the following IDLE cycle → awvalid/wvalid the cycle after, with no stale re-issue of the read.
- rst asserted while in R with rvalid low → the next cycle shows all valids 0, state IDLE, data_valid 0; a fresh read afterwards completes normally.

Source files
------------

// File: rtl/ysyx_040066_dmem_pkg.sv
// Shared types and constants for the data-side memory bridge: FSM states,
// access size encodings, bus response codes and the alignment check.
package ysyx_040066_dmem_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_R    = 3'd2,
        S_W    = 3'd3,
        S_B    = 3'd4,
        S_RESP = 3'd5
    } dmem_state_e;

    localparam logic [2:0] SZ_B = 3'd0;
    localparam logic [2:0] SZ_H = 3'd1;
    localparam logic [2:0] SZ_W = 3'd2;
    localparam logic [2:0] SZ_D = 3'd3;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    // Sizes above 8B are never aligned, so they also fault here.
    function automatic logic is_aligned(input logic [2:0] lo, input logic [2:0] len);
        logic ok;
        case (len)
            SZ_B:    ok = 1'b1;
            SZ_H:    ok = (lo[0] == 1'b0);
            SZ_W:    ok = (lo[1:0] == 2'b00);
            SZ_D:    ok = (lo == 3'b000);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ysyx_040066_dmem_bridge.sv
// Single-outstanding data memory bridge: turns the core's M-stage request into
// one AXI4-lite-style read or write and returns the raw beat with a done pulse.
module ysyx_040066_dmem_bridge
    import ysyx_040066_dmem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MemRd,
    input  logic                  MemWr,
    input  logic [63:0]           addr,
    input  logic [2:0]            wr_len,
    input  logic [DATA_W/8-1:0]   wr_mask,
    input  logic [DATA_W-1:0]     data_Wr,
    output logic [DATA_W-1:0]     data_Rd,
    output logic                  data_valid,
    output logic                  data_error,
    output logic [ADDR_W-1:0]     araddr,
    output logic [2:0]            arsize,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_W-1:0]     rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [ADDR_W-1:0]     awaddr,
    output logic [2:0]            awsize,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   wstrb,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready,
    output dmem_state_e           dbg_state_o
);

    // Handshake rule on every channel: a transfer happens in a cycle where
    // valid and ready are both high at the clock edge; valid never drops
    // before that transfer, and ready may be asserted independently of valid.

    dmem_state_e           state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [2:0]            len_q, len_d;
    logic [DATA_W/8-1:0]   mask_q, mask_d;
    logic [DATA_W-1:0]     wdat_q, wdat_d;
    logic [DATA_W-1:0]     rdat_q, rdat_d;
    logic                  err_q, err_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  bready_q, bready_d;
    logic                  dvalid_q, dvalid_d;
    logic                  derr_q, derr_d;

    logic                  pre_fault;
    logic                  aw_pend;
    logic                  w_pend;

    assign pre_fault = (MemRd && MemWr)
                    || (wr_len > SZ_D)
                    || ((addr >> ADDR_W) != 64'd0)
                    || !is_aligned(addr[2:0], wr_len);

    // Each write channel stays pending until its own handshake lands.
    assign aw_pend = awvalid_q && !awready;
    assign w_pend  = wvalid_q && !wready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        mask_d  = mask_q;
        wdat_d  = wdat_q;
        rdat_d  = rdat_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (MemRd || MemWr) begin
                    addr_d = addr[ADDR_W-1:0];
                    len_d  = wr_len;
                    mask_d = wr_mask;
                    wdat_d = data_Wr;
                    if (pre_fault) begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = MemRd ? S_AR : S_W;
                    end
                end
            end
            S_AR: begin
                if (arvalid_q && arready) state_d = S_R;
            end
            S_R: begin
                if (rready_q && rvalid) begin
                    rdat_d  = rdata;
                    err_d   = (rresp != OKAY);
                    state_d = S_RESP;
                end
            end
            S_W: begin
                if (!aw_pend && !w_pend) state_d = S_B;
            end
            S_B: begin
                if (bready_q && bvalid) begin
                    err_d   = (bresp != OKAY);
                    state_d = S_RESP;
                end
            end
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered, so they are derived from the next state.
        arvalid_d = (state_d == S_AR);
        rready_d  = (state_d == S_R);
        bready_d  = (state_d == S_B);
        dvalid_d  = (state_d == S_RESP);
        derr_d    = (state_d == S_RESP) && err_d;

        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        if (state_q == S_IDLE && state_d == S_W) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
        end else if (state_q == S_W) begin
            awvalid_d = aw_pend;
            wvalid_d  = w_pend;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            mask_q    <= '0;
            wdat_q    <= '0;
            rdat_q    <= '0;
            err_q     <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            dvalid_q  <= 1'b0;
            derr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            mask_q    <= mask_d;
            wdat_q    <= wdat_d;
            rdat_q    <= rdat_d;
            err_q     <= err_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            dvalid_q  <= dvalid_d;
            derr_q    <= derr_d;
        end
    end

    assign data_Rd     = rdat_q;
    assign data_valid  = dvalid_q;
    assign data_error  = derr_q;
    assign araddr      = addr_q;
    assign arsize      = len_q;
    assign arvalid     = arvalid_q;
    assign rready      = rready_q;
    assign awaddr      = addr_q;
    assign awsize      = len_q;
    assign awvalid     = awvalid_q;
    assign wdata       = wdat_q;
    assign wstrb       = mask_q;
    assign wvalid      = wvalid_q;
    assign bready      = bready_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ysyx_040066_dmem_bridge.sv
// Directed bench for the data memory bridge with a delay-configurable slave.
module tb_ysyx_040066_dmem_bridge;
    import ysyx_040066_dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MemRd = 1'b0, MemWr = 1'b0;
    logic [63:0] addr = '0;
    logic [2:0]  wr_len = '0;
    logic [7:0]  wr_mask = '0;
    logic [63:0] data_Wr = '0;
    logic [63:0] data_Rd;
    logic        data_valid, data_error;
    logic [31:0] araddr, awaddr;
    logic [2:0]  arsize, awsize;
    logic        arvalid, rready, awvalid, wvalid, bready;
    logic        arready = 1'b0, rvalid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
    logic [63:0] rdata, wdata;
    logic [1:0]  rresp, bresp;
    logic [7:0]  wstrb;
    dmem_state_e dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    // slave configuration, written only by the stimulus process
    int          ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
    logic [63:0] sl_rdata = '0;
    logic [1:0]  sl_rresp = 2'b00, sl_bresp = 2'b00;

    // monitor state, written only by the slave process
    int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    int ar_hi = 0, aw_hi = 0, w_hi = 0;
    logic [31:0] araddr_seen = '0;
    logic [2:0]  arsize_seen = '0;
    logic [7:0]  wstrb_seen = '0;
    logic [63:0] wdata_seen = '0;

    assign rdata = sl_rdata;
    assign rresp = sl_rresp;
    assign bresp = sl_bresp;

    ysyx_040066_dmem_bridge #(.ADDR_W(32), .DATA_W(64)) dut (
        .clk(clk), .rst(rst), .MemRd(MemRd), .MemWr(MemWr), .addr(addr),
        .wr_len(wr_len), .wr_mask(wr_mask), .data_Wr(data_Wr), .data_Rd(data_Rd),
        .data_valid(data_valid), .data_error(data_error),
        .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready), .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    // Slave: each ready/valid answers after its configured number of waiting cycles.
    always @(negedge clk) begin
        if (arvalid) begin
            ar_hi++; araddr_seen = araddr; arsize_seen = arsize;
            arready = (ar_cnt >= ar_dly); ar_cnt++;
        end else begin arready = 1'b0; ar_cnt = 0; end
        if (rready) begin rvalid = (r_cnt >= r_dly); r_cnt++; end
        else begin rvalid = 1'b0; r_cnt = 0; end
        if (awvalid) begin aw_hi++; awready = (aw_cnt >= aw_dly); aw_cnt++; end
        else begin awready = 1'b0; aw_cnt = 0; end
        if (wvalid) begin
            w_hi++; wstrb_seen = wstrb; wdata_seen = wdata;
            wready = (w_cnt >= w_dly); w_cnt++;
        end else begin wready = 1'b0; w_cnt = 0; end
        if (bready) begin bvalid = (b_cnt >= b_dly); b_cnt++; end
        else begin bvalid = 1'b0; b_cnt = 0; end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk); #1;
    endtask

    // Present a request and wait for the completion pulse; optionally release it.
    task automatic do_req(input logic rd, input logic wr, input logic [63:0] a,
                          input logic [2:0] len, input logic [7:0] mask,
                          input logic [63:0] wd, input logic release_req,
                          output int lat, output logic err);
        bit seen = 0;
        MemRd = rd; MemWr = wr; addr = a; wr_len = len; wr_mask = mask; data_Wr = wd;
        lat = 0; err = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            tick();
            lat++;
            if (data_valid) begin seen = 1; err = data_error; end
        end
        if (!seen) check("timeout_data_valid", 64'd0, 64'd1);
        if (release_req) begin
            MemRd = 1'b0; MemWr = 1'b0;
            tick();
            check("pulse_once", 64'(data_valid), 64'd0);
        end
    endtask

    initial begin
        int lat;
        logic err;
        int ar0, aw0, w0;
        bit seen;

        repeat (3) tick();
        rst = 1'b0;
        check("rst_data_valid", 64'(data_valid), 64'd0);
        check("rst_data_error", 64'(data_error), 64'd0);
        check("rst_data_Rd", data_Rd, 64'd0);
        check("rst_valids", {59'd0, arvalid, rready, awvalid, wvalid, bready}, 64'd0);
        check("rst_state", 64'(dbg_state), 64'(S_IDLE));

        // aligned 8B read, zero-wait slave
        sl_rdata = 64'h1122334455667788; sl_rresp = OKAY;
        ar0 = ar_hi;
        do_req(1, 0, 64'h80000008, SZ_D, 8'hFF, 64'd0, 1, lat, err);
        check("rd8_latency", 64'(lat), 64'd3);
        check("rd8_error", 64'(err), 64'd0);
        check("rd8_data", data_Rd, 64'h1122334455667788);
        check("rd8_arsize", 64'(arsize_seen), 64'd3);
        check("rd8_araddr", 64'(araddr_seen), 64'h80000008);
        check("rd8_ar_cycles", 64'(ar_hi - ar0), 64'd1);

        // 4B write, awready two cycles late
        aw_dly = 2; w_dly = 0; b_dly = 0; sl_bresp = OKAY;
        aw0 = aw_hi; w0 = w_hi;
        do_req(0, 1, 64'h80000004, SZ_W, 8'hF0, 64'hAABBCCDD00000000, 1, lat, err);
        check("wr4_latency", 64'(lat), 64'd5);
        check("wr4_error", 64'(err), 64'd0);
        check("wr4_aw_cycles", 64'(aw_hi - aw0), 64'd3);
        check("wr4_w_cycles", 64'(w_hi - w0), 64'd1);
        check("wr4_wstrb", 64'(wstrb_seen), 64'hF0);
        check("wr4_wdata", wdata_seen, 64'hAABBCCDD00000000);
        check("wr4_data_Rd_kept", data_Rd, 64'h1122334455667788);
        aw_dly = 0;

        // misaligned 2B read faults without bus traffic
        ar0 = ar_hi;
        do_req(1, 0, 64'h80000001, SZ_H, 8'h03, 64'd0, 1, lat, err);
        check("mis_latency", 64'(lat), 64'd1);
        check("mis_error", 64'(err), 64'd1);
        check("mis_no_ar", 64'(ar_hi - ar0), 64'd0);

        // slave error on read
        sl_rresp = SLVERR; sl_rdata = 64'h0BAD0BAD0BAD0BAD;
        do_req(1, 0, 64'h80000010, SZ_D, 8'hFF, 64'd0, 1, lat, err);
        check("slverr_latency", 64'(lat), 64'd3);
        check("slverr_error", 64'(err), 64'd1);
        sl_rresp = OKAY;

        // address above the bus range
        ar0 = ar_hi; aw0 = aw_hi;
        do_req(1, 0, 64'h1_0000_0000, SZ_D, 8'hFF, 64'd0, 1, lat, err);
        check("hiaddr_latency", 64'(lat), 64'd1);
        check("hiaddr_error", 64'(err), 64'd1);
        check("hiaddr_no_bus", 64'((ar_hi - ar0) + (aw_hi - aw0)), 64'd0);

        // read and write together, and an oversized access
        do_req(1, 1, 64'h80000000, SZ_D, 8'hFF, 64'd0, 1, lat, err);
        check("rdwr_error", 64'(err), 64'd1);
        do_req(0, 1, 64'h80000000, 3'd4, 8'hFF, 64'd0, 1, lat, err);
        check("len4_error", 64'(err), 64'd1);

        // back-to-back: write held in the IDLE cycle right after a read
        sl_rdata = 64'h0123456789ABCDEF;
        do_req(1, 0, 64'h80000020, SZ_D, 8'hFF, 64'd0, 0, lat, err);
        check("b2b_rd_data", data_Rd, 64'h0123456789ABCDEF);
        MemRd = 1'b0; MemWr = 1'b1; addr = 64'h80000028; wr_len = SZ_D;
        wr_mask = 8'hFF; data_Wr = 64'hCAFEF00DCAFEF00D;
        ar0 = ar_hi;
        tick();
        check("b2b_idle_valids", {61'd0, arvalid, awvalid, wvalid}, 64'd0);
        tick();
        check("b2b_aw_w_up", {61'd0, arvalid, awvalid, wvalid}, 64'd3);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (data_valid) begin seen = 1; check("b2b_wr_error", 64'(data_error), 64'd0); end
        end
        if (!seen) check("timeout_b2b", 64'd0, 64'd1);
        check("b2b_no_stale_ar", 64'(ar_hi - ar0), 64'd0);
        MemWr = 1'b0;
        tick();

        // reset while waiting in R
        r_dly = 100;
        MemRd = 1'b1; addr = 64'h80000030; wr_len = SZ_D;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (rready) seen = 1;
        end
        if (!seen) check("timeout_reach_R", 64'd0, 64'd1);
        rst = 1'b1;
        tick();
        check("midrst_valids", {58'd0, arvalid, rready, awvalid, wvalid, bready, data_valid}, 64'd0);
        check("midrst_state", 64'(dbg_state), 64'(S_IDLE));
        check("midrst_data_Rd", data_Rd, 64'd0);
        rst = 1'b0; MemRd = 1'b0; r_dly = 0;
        tick();
        sl_rdata = 64'hFEEDFACE12345678;
        do_req(1, 0, 64'h80000038, SZ_D, 8'hFF, 64'd0, 1, lat, err);
        check("post_rst_latency", 64'(lat), 64'd3);
        check("post_rst_error", 64'(err), 64'd0);
        check("post_rst_data", data_Rd, 64'hFEEDFACE12345678);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
